pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined add/subtract unit and the next generation of the team's 4-bit ripple-carry adder. A WIDTH-bit ripple chain is split into STAGES registered segments so long operands close timing, and a mode input selects subtraction. Sits between operand producers and consumers on a valid/ready stream, accepting one operation per cycle with fixed latency.

Parameters:
WIDTH, 16, operand/result width in bits; WIDTH >= 1
STAGES, 4, pipeline segments; WIDTH % STAGES == 0; segment width SEG = WIDTH/STAGES; STAGES >= 1

Ports:
clk  input  1  sole clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A (unsigned / two's complement)
b  input  WIDTH  operand B
cin  input  1  carry-in; used only when sub=0
sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1, cin ignored)
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry out of MSB (sub=1: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1 at clk edge): all stage valid bits, out_valid, sum, cout, ovf cleared to 0; in_ready reads 1 in the cycle after reset deasserts. Reset mid-operation discards all in-flight beats; nothing emerges afterwards.
- Accept: beat transfers on a clk edge with in_valid && in_ready. At acceptance, b is replaced by ~b and the carry-in by 1 when sub=1.
- Stage k (0..STAGES-1) adds slice [k*SEG +: SEG] of A and the effective B, with the carry from stage k-1 (stage 0 uses the effective carry-in). It registers the partial sum and carry-out.
- Upper operand slices are skewed: they are carried forward in registers until their stage. Lower result slices are deskewed: they are delayed so all slices of one beat reach the output together.
- Stage STAGES-1 also registers the carry into its MSB for ovf.
- Latency: result appears on out_valid exactly STAGES cycles after acceptance when unstalled. STAGES=1 gives one registered full-width adder with 1-cycle latency.
- Throughput: 1 beat/cycle. Beats leave in acceptance order, with none lost or duplicated.
- Flow control: whole pipeline advances iff (!out_valid || out_ready). in_ready = !out_valid || out_ready, so it is combinational from out_ready. When stalled, every stage, valid bit and output holds its value.
- Bubbles: a cycle with no accept inserts an invalid slot, which advances like data. out_valid=0 for bubbles, and sum/cout/ovf keep their last values.
- Output stability: while out_valid && !out_ready, sum/cout/ovf/out_valid are held constant.
- Simultaneous accept and emit in the same cycle under out_ready=1 is legal and the normal steady state.
- Width rules: sum is modulo 2^WIDTH, with no saturation. cout and ovf are computed per the full WIDTH chain, independent of segmentation.

Test Plan:
- WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0, out_valid pulses 1 cycle.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1; carry crosses all 3 segment boundaries.
- Subtraction: a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Stream 8 back-to-back beats (a=i, b=0x0100*i); drop out_ready for 3 cycles mid-stream -> in_ready low the same cycles; outputs held; all 8 results correct, in order, no gaps once out_ready returns.
- Assert rst for 1 cycle with 3 beats in flight -> out_valid=0, sum=0x0000 from next cycle; no stale beat ever appears; new beat accepted right after produces a correct result at latency 4.
- Re-run scenarios 1–3 with STAGES=1 and STAGES=16 -> identical sum/cout/ovf, latency 1 and 16 respectively.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract unit: a WIDTH-bit ripple chain split into STAGES registered
// segments on a valid/ready stream, one beat per cycle, fixed latency of STAGES cycles.
module pipelined_addsub #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SEG = WIDTH / STAGES;
   localparam int unsigned NB  = (STAGES > 1) ? STAGES - 1 : 1;

   logic advance;

   // Stage inputs: from the ports for stage 0, from the previous stage's registers otherwise
   logic [WIDTH-1:0] x_in [STAGES];
   logic [WIDTH-1:0] b_in [STAGES];
   logic             c_in [STAGES];
   logic             v_in [STAGES];

   // x holds finished sum slices below the stage boundary and still-skewed A slices above it
   logic [WIDTH-1:0] x_q [STAGES];
   logic             c_q [STAGES];
   logic             v_q [STAGES];
   logic [WIDTH-1:0] b_q [NB];
   logic             ovf_q;

   assign advance  = !v_q[STAGES-1] || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] x_nxt;

      if (k == 0) begin : g_head
         // Subtraction folds into the adder as A + ~B + 1
         assign x_in[0] = a;
         assign b_in[0] = sub ? ~b : b;
         assign c_in[0] = sub | cin;
         assign v_in[0] = in_valid;
      end else begin : g_link
         assign x_in[k] = x_q[k-1];
         assign b_in[k] = b_q[k-1];
         assign c_in[k] = c_q[k-1];
         assign v_in[k] = v_q[k-1];
      end

      assign seg_sum = {1'b0, x_in[k][k*SEG +: SEG]} + {1'b0, b_in[k][k*SEG +: SEG]}
                     + (SEG+1)'(c_in[k]);

      always_comb begin
         x_nxt                 = x_in[k];
         x_nxt[k*SEG +: SEG]   = seg_sum[SEG-1:0];
      end

      // Data only loads on valid slots so bubbles leave the last result in place
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q[k] <= 1'b0;
            x_q[k] <= '0;
            c_q[k] <= 1'b0;
         end else if (advance) begin
            v_q[k] <= v_in[k];
            if (v_in[k]) begin
               x_q[k] <= x_nxt;
               c_q[k] <= seg_sum[SEG];
            end
         end
      end

      if (k < STAGES - 1) begin : g_skew
         always_ff @(posedge clk) begin
            if (rst) begin
               b_q[k] <= '0;
            end else if (advance && v_in[k]) begin
               b_q[k] <= b_in[k];
            end
         end
      end else begin : g_tail
         logic carry_msb;

         // Carry into the MSB recovered from the MSB's own sum bit
         assign carry_msb = x_in[k][WIDTH-1] ^ b_in[k][WIDTH-1] ^ x_nxt[WIDTH-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (advance && v_in[k]) begin
               ovf_q <= carry_msb ^ seg_sum[SEG];
            end
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign sum       = x_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: driver pushes model results on accept,
// a monitor pops and compares whenever the DUT presents a result.
module tb_pipelined_addsub;

   localparam int unsigned W      = 16;
   localparam int unsigned STAGES = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   pipelined_addsub #(.WIDTH(W), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           acc;
      bit           lat;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference: plain integer arithmetic on the whole operands
   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                  input logic tcin, input logic tsub);
      exp_t   e;
      longint ua, ub, sa, sbv, u, r;
      longint smax, smin;
      ua   = longint'(ta);
      ub   = longint'(tb_);
      sa   = longint'($signed(ta));
      sbv  = longint'($signed(tb_));
      smax = (longint'(1) <<< (W - 1)) - 1;
      smin = -(longint'(1) <<< (W - 1));
      if (tsub) begin
         e.cout = (ua >= ub);
         e.sum  = W'(ua - ub);
         r      = sa - sbv;
      end else begin
         u      = ua + ub + longint'(tcin);
         e.cout = ((u >>> W) != 0);
         e.sum  = W'(u);
         r      = sa + sbv + longint'(tcin);
      end
      e.ovf = (r > smax) || (r < smin);
      e.acc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   // One cycle of stimulus; in_ready is checked against the model when chk_rdy is set
   task automatic drive(input bit vld, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tcin, input logic tsub, input bit ordy, input bit lat,
                        input bit chk_rdy, output bit acc);
      exp_t e;
      bit   exp_ov;
      @(negedge clk);
      in_valid  = vld;
      a         = ta;
      b         = tb_;
      cin       = tcin;
      sub       = tsub;
      out_ready = ordy;
      #1;
      if (chk_rdy) begin
         exp_ov = (sb.size() > 0) && ((cyc - sb[0].acc) >= int'(STAGES));
         chk("in_ready", 32'(in_ready), 32'(ordy || !exp_ov));
      end
      acc = vld && in_ready;
      if (acc) begin
         e     = model(ta, tb_, tcin, tsub);
         e.acc = cyc;
         e.lat = lat;
         sb.push_back(e);
      end
   endtask

   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                       input logic tsub, input bit lat);
      bit acc;
      int tries;
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 100) begin
         drive(1'b1, ta, tb_, tcin, tsub, 1'b1, lat, 1'b1, acc);
         tries++;
      end
      if (!acc) chk("send_timeout", 32'(acc), 32'(1));
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         idle(1);
         n++;
      end
      chk("drain_left", 32'(sb.size()), 32'(0));
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         2:       return ($urandom_range(0, 1) != 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         default: return W'($urandom);
      endcase
   endfunction

   // Monitor: compares the presented result to the queue head, pops on transfer
   logic [W-1:0] last_sum;
   logic         last_cout;
   logic         last_ovf;
   bit           holding = 1'b0;
   int           first_seen = 0;

   always @(negedge clk) begin
      #2;
      if (rst) begin
         holding   = 1'b0;
         last_sum  = '0;
         last_cout = 1'b0;
         last_ovf  = 1'b0;
      end else if (out_valid) begin
         if (!holding) first_seen = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_beat", 32'(out_valid), 32'(0));
         end else begin
            chk("sum",  32'(sum),  32'(sb[0].sum));
            chk("cout", 32'(cout), 32'(sb[0].cout));
            chk("ovf",  32'(ovf),  32'(sb[0].ovf));
            if (out_ready) begin
               if (sb[0].lat) chk("latency", 32'(first_seen - sb[0].acc), 32'(STAGES));
               last_sum  = sb[0].sum;
               last_cout = sb[0].cout;
               last_ovf  = sb[0].ovf;
               void'(sb.pop_front());
               holding = 1'b0;
            end else begin
               holding = 1'b1;
            end
         end
      end else begin
         holding = 1'b0;
         chk("bubble_sum",  32'(sum),  32'(last_sum));
         chk("bubble_cout", 32'(cout), 32'(last_cout));
         chk("bubble_ovf",  32'(ovf),  32'(last_ovf));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d beats outstanding", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int i;
      int t;
      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_sum",       32'(sum),       32'(0));
      chk("rst_cout",      32'(cout),      32'(0));
      chk("rst_ovf",       32'(ovf),       32'(0));
      chk("rst_in_ready",  32'(in_ready),  32'(1));

      // Directed corner cases, isolated then back-to-back
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      idle(STAGES + 2);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
      send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
      send(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
      drain();

      // Eight back-to-back beats with a three-cycle output stall mid-stream
      i = 0;
      t = 0;
      while (i < 8 && t < 100) begin
         drive(1'b1, W'(i), W'(i * 256), 1'b0, 1'b0, !(t >= 5 && t < 8), 1'b0, 1'b1, acc);
         if (acc) i++;
         t++;
      end
      drain();

      // Reset with beats in flight: they must vanish
      send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
      send(16'h3333, 16'h4444, 1'b1, 1'b0, 1'b1);
      send(16'h5555, 16'h0001, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_sum",       32'(sum),       32'(0));
      chk("midrst_in_ready",  32'(in_ready),  32'(1));
      send(16'hABCD, 16'h1234, 1'b1, 1'b0, 1'b1);
      idle(STAGES + 4);
      drain();

      // Random traffic with random bubbles and backpressure
      for (int n = 0; n < 400; n++) begin
         bit vld;
         bit ordy;
         vld  = ($urandom_range(0, 4) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         drive(vld, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), ordy, 1'b0, ordy, acc);
      end
      drain();
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
